// File: rtl/noc_pkg.sv
// Shared definitions for the 5-port XY mesh router: port indices, header
// field offsets and the dimension-ordered route decode.
package noc_pkg;

  localparam int unsigned NUM_PORTS  = 5;
  localparam int unsigned PORT_W     = 3;
  localparam int unsigned PORT_SUM_W = PORT_W + 1;
  localparam int unsigned COORD_W    = 8;

  typedef enum logic [PORT_W-1:0] {
    P_E = 3'd0,
    P_W = 3'd1,
    P_N = 3'd2,
    P_S = 3'd3,
    P_L = 3'd4
  } port_e;

  // Destination X sits in the top bits of the packet, destination Y just below.
  function automatic int unsigned hdr_dx_lsb(input int unsigned pkt_w,
                                             input int unsigned x_w);
    return pkt_w - x_w;
  endfunction

  function automatic int unsigned hdr_dy_lsb(input int unsigned pkt_w,
                                             input int unsigned x_w,
                                             input int unsigned y_w);
    return pkt_w - x_w - y_w;
  endfunction

  // X is resolved before Y; coordinates are zero-extended to COORD_W.
  function automatic port_e route_xy(input logic [COORD_W-1:0] dest_x,
                                     input logic [COORD_W-1:0] own_x,
                                     input logic [COORD_W-1:0] dest_y,
                                     input logic [COORD_W-1:0] own_y);
    if (dest_x > own_x)      return P_E;
    else if (dest_x < own_x) return P_W;
    else if (dest_y > own_y) return P_N;
    else if (dest_y < own_y) return P_S;
    else                     return P_L;
  endfunction

  // Port index addition modulo NUM_PORTS, used by the round-robin search.
  function automatic logic [PORT_W-1:0] port_add(input logic [PORT_W-1:0] a,
                                                 input logic [PORT_W-1:0] b);
    logic [PORT_SUM_W-1:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    if (sum >= PORT_SUM_W'(NUM_PORTS)) begin
      sum = sum - PORT_SUM_W'(NUM_PORTS);
    end
    return sum[PORT_W-1:0];
  endfunction

endpackage

// File: rtl/noc_fifo.sv
// Per-input packet FIFO. A written entry becomes readable one cycle after
// the write, which gives the router its two-edge input-to-output latency.
module noc_fifo #(
  parameter int unsigned WIDTH = 34,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic             o_full_c,
  output logic             o_valid_c,
  output logic [WIDTH-1:0] o_data_c
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             r_push_q;
  logic             w_push;
  logic             w_pop;

  assign w_push = i_push && !o_full_c;
  assign w_pop  = i_pop && o_valid_c;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_push_q <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      r_push_q <= w_push;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

  // With more than one entry the head is never the most recent write.
  assign o_full_c  = (r_count == CW'(DEPTH));
  assign o_valid_c = (r_count > CW'(1)) || ((r_count == CW'(1)) && !r_push_q);
  assign o_data_c  = r_mem[r_rd_ptr];

endmodule

// File: rtl/noc_router.sv
// Five-port XY mesh router: input FIFOs, head route decode with u-turn
// redirect to local, round-robin output arbitration and one-entry output regs.
module noc_router
  import noc_pkg::*;
#(
  parameter  int unsigned X_W        = 2,
  parameter  int unsigned Y_W        = 2,
  parameter  int unsigned PAYLOAD_W  = 30,
  parameter  int unsigned FIFO_DEPTH = 4,
  localparam int unsigned PKT_W      = X_W + Y_W + PAYLOAD_W
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [X_W-1:0]                      my_x,
  input  logic [Y_W-1:0]                      my_y,
  input  logic [NUM_PORTS-1:0]                in_req,
  input  logic [NUM_PORTS-1:0][PKT_W-1:0]     in_pkt,
  output logic [NUM_PORTS-1:0]                in_ack,
  output logic [NUM_PORTS-1:0]                out_req,
  output logic [NUM_PORTS-1:0][PKT_W-1:0]     out_pkt,
  input  logic [NUM_PORTS-1:0]                out_ack,
  output logic                                err_uturn
);

  localparam int unsigned DX_LSB = hdr_dx_lsb(PKT_W, X_W);
  localparam int unsigned DY_LSB = hdr_dy_lsb(PKT_W, X_W, Y_W);

  logic [NUM_PORTS-1:0]                w_full;
  logic [NUM_PORTS-1:0]                w_valid;
  logic [NUM_PORTS-1:0]                w_pop;
  logic [NUM_PORTS-1:0]                w_uturn;
  logic [NUM_PORTS-1:0][PKT_W-1:0]     w_head;
  logic [NUM_PORTS-1:0][PORT_W-1:0]    w_route;
  logic [NUM_PORTS-1:0][NUM_PORTS-1:0] w_req_oh;
  logic [NUM_PORTS-1:0]                w_free;
  logic [NUM_PORTS-1:0]                w_grant_vld;
  logic [NUM_PORTS-1:0][PORT_W-1:0]    w_grant_sel;
  logic [PORT_W-1:0]                   w_cand;

  logic [NUM_PORTS-1:0]                r_out_req;
  logic [NUM_PORTS-1:0][PKT_W-1:0]     r_out_pkt;
  logic [NUM_PORTS-1:0][PORT_W-1:0]    r_rr_ptr;
  logic                                r_err_uturn;

  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_in
    logic [X_W-1:0]    w_dx;
    logic [Y_W-1:0]    w_dy;
    logic [PORT_W-1:0] w_raw;

    noc_fifo #(
      .WIDTH (PKT_W),
      .DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .i_push    (in_req[g]),
      .i_data    (in_pkt[g]),
      .i_pop     (w_pop[g]),
      .o_full_c  (w_full[g]),
      .o_valid_c (w_valid[g]),
      .o_data_c  (w_head[g])
    );

    // Head routing; a head that would turn back out of its own port goes local.
    always_comb begin
      w_dx       = w_head[g][DX_LSB +: X_W];
      w_dy       = w_head[g][DY_LSB +: Y_W];
      w_raw      = route_xy(COORD_W'(w_dx), COORD_W'(my_x),
                            COORD_W'(w_dy), COORD_W'(my_y));
      w_uturn[g] = (PORT_W'(g) != P_L) && (w_raw == PORT_W'(g));
      w_route[g] = w_uturn[g] ? P_L : w_raw;
      w_req_oh[g] = w_valid[g] ? (NUM_PORTS'(1) << w_route[g]) : '0;
    end
  end

  // Round-robin per output; each head requests exactly one output so it can
  // never be granted twice in a cycle.
  always_comb begin
    w_free      = '0;
    w_grant_vld = '0;
    w_grant_sel = '0;
    w_pop       = '0;
    w_cand      = '0;
    for (int unsigned o = 0; o < NUM_PORTS; o++) begin
      w_free[o] = !r_out_req[o] || out_ack[o];
      for (int unsigned k = 0; k < NUM_PORTS; k++) begin
        w_cand = port_add(r_rr_ptr[o], PORT_W'(k));
        if (w_free[o] && !w_grant_vld[o] && w_req_oh[w_cand][o]) begin
          w_grant_vld[o] = 1'b1;
          w_grant_sel[o] = w_cand;
          w_pop[w_cand]  = 1'b1;
        end
      end
    end
  end

  // Output registers hold until accepted; pointer moves past the winner.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_req   <= '0;
      r_out_pkt   <= '0;
      r_rr_ptr    <= '0;
      r_err_uturn <= 1'b0;
    end else begin
      for (int unsigned o = 0; o < NUM_PORTS; o++) begin
        if (w_free[o]) begin
          r_out_req[o] <= w_grant_vld[o];
          if (w_grant_vld[o]) begin
            r_out_pkt[o] <= w_head[w_grant_sel[o]];
            r_rr_ptr[o]  <= port_add(w_grant_sel[o], PORT_W'(1));
          end
        end
      end
      if (|(w_uturn & w_valid)) r_err_uturn <= 1'b1;
    end
  end

  assign in_ack    = ~w_full;
  assign out_req   = r_out_req;
  assign out_pkt   = r_out_pkt;
  assign err_uturn = r_err_uturn;

endmodule

// File: doc/noc_router.md
NOC_ROUTER -- requirements
Module: noc_router

Interface
REQ-001 Parameter X_W, default 2, destination/own X coordinate width.
REQ-002 Parameter Y_W, default 2, destination/own Y coordinate width.
REQ-003 Parameter PAYLOAD_W, default 30, payload width; PKT_W = X_W+Y_W+PAYLOAD_W (34 at defaults).
REQ-004 Parameter FIFO_DEPTH, default 4, entries per input FIFO, power of two, >=2.
REQ-005 Port index order for all [4:0] vectors and [4:0][PKT_W-1:0] arrays: 0=E, 1=W, 2=N, 3=S, 4=L (local scheduler).
REQ-006 One clock; reset is synchronous and active-high.
REQ-007 clk  in  1  clock; all state updates on rising edge.
REQ-008 rst  in  1  synchronous active-high reset.
REQ-009 my_x  in  X_W  own X coordinate, static after reset.
REQ-010 my_y  in  Y_W  own Y coordinate, static after reset.
REQ-011 in_req  in  5  per-port packet-offered request.
REQ-012 in_pkt  in  5xPKT_W  per-port packet; [PKT_W-1 -: X_W]=dest_x, next Y_W bits=dest_y, rest payload.
REQ-013 in_ack  out  5  per-port accept; transfer on cycle where in_req&in_ack.
REQ-014 out_req  out  5  per-port packet-valid toward neighbour/scheduler.
REQ-015 out_pkt  out  5xPKT_W  per-port packet, unmodified from input.
REQ-016 out_ack  in  5  per-port accept from downstream; transfer on out_req&out_ack.
REQ-017 err_uturn  out  1  sticky flag: a packet arrived whose route equals its input port.

Function
REQ-018 Each input port SHALL have a FIFO_DEPTH FIFO; in_ack = !full (registered-state only, not counting a same-cycle pop).
REQ-019 Write and pop in the same cycle on a non-empty FIFO SHALL keep occupancy unchanged; pointers wrap modulo FIFO_DEPTH.
REQ-020 Route of FIFO head (XY order): dest_x>my_x ->E; dest_x<my_x ->W; else dest_y>my_y ->N; dest_y<my_y ->S; else L.
REQ-021 A head whose route equals its own input port (ports 0-3) SHALL be redirected to L and set err_uturn.
REQ-022 Each output SHALL have a one-entry output register; it is free when !out_req or (out_req&out_ack).
REQ-023 Each free output SHALL grant one requesting head by round-robin, starting from the index after the last granted; pointer advances only on grant.
REQ-024 Each input head SHALL be granted to at most one output per cycle; granted head pops the same cycle.
REQ-025 out_req and out_pkt SHALL be held stable until out_ack; back-to-back transfers (one per cycle per output) SHALL be supported.
REQ-026 Latency: packet accepted at edge t, uncontended, empty path -> out_req high after edge t+2.
REQ-027 Packets from one input to one output SHALL leave in arrival order; no packet dropped or duplicated.
REQ-028 Five inputs to five distinct outputs SHALL all progress in the same cycle (non-blocking crossbar).

Reset
REQ-029 On rst: all FIFOs empty, in_ack=5'b11111 on next cycle, out_req=0, out_pkt=0, RR pointers=0, err_uturn=0.
REQ-030 rst mid-transfer SHALL discard all buffered packets; no out_req in the cycle after rst.

Structure
REQ-031 Package noc_pkg: port index constants (P_E..P_L), NUM_PORTS=5, route-decode function, header field offsets.
REQ-032 Sub-module noc_fifo (parametrised width/depth, push/pop/full/empty) instantiated five times; arbiter and routing inline.

Verification
REQ-033 my=(1,1), E in_pkt dest=(2,1) payload 0x1 -> out_req[E] after 2 edges, out_pkt equal, err_uturn=0.
REQ-034 my=(1,1), dest=(1,1) on N -> appears on L; dest=(1,3) on E -> routed N (X resolved first).
REQ-035 E,W,N,S all send dest=(1,1) simultaneously, out_ack[L]=1 -> L outputs in RR order E,W,N,S, one per cycle.
REQ-036 out_ack[E]=0 held, W streams 6 packets dest=(3,1) -> in_ack[W] drops after 4+1 accepted; release -> all 6 in order.
REQ-037 E sends dest=(3,1) from my=(1,1) -> delivered on L, err_uturn=1 until rst.
REQ-038 rst asserted with 3 packets buffered -> next cycle out_req=0, in_ack=all ones, none emitted afterwards.
